// File: rtl/acquisition_sequencer.sv
// Acquisition sequencer: resets the comparator, arms TriggerControl, then gates
// POST_TRIG_SAMPLES capture cycles; optional auto-trigger under `ACQ_AUTO_TRIG_EN.
module acquisition_sequencer #(
  parameter int POST_TRIG_SAMPLES = 1024,
  parameter int CNT_W             = 16,
  parameter int COMP_RESET_CYCLES = 4,
  parameter int HOLDOFF_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES    = 4096,
  parameter int TRIG_CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  module_reset,
  input  logic                  start_cmd,
  input  logic                  stop_cmd,
  input  logic                  continuous,
  input  logic                  triggered_in,
  input  logic                  fifo_full,
  output logic                  armed_out,
  output logic                  manual_reset_out,
  output logic                  manual_trigger_out,
  output logic                  capture_en,
  output logic                  acq_done,
  output logic                  overflow,
  output logic [TRIG_CNT_W-1:0] trig_count,
  output logic [2:0]            state_out
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COMP_RST = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_CAPTURE  = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [CNT_W-1:0] CR_LAST  = CNT_W'(COMP_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(POST_TRIG_SAMPLES - 1);
  localparam logic [CNT_W-1:0] HO_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

  if (POST_TRIG_SAMPLES < 1 || COMP_RESET_CYCLES < 1 || HOLDOFF_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("acquisition_sequencer: cycle-count parameters must be >= 1");
  end

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_last;
  logic                  w_cnt_done;
  logic                  w_restart;
  logic                  w_trig_accept;
  logic                  w_ovf_set;
  logic                  w_mtrig;
  logic                  r_armed;
  logic                  r_mreset;
  logic                  r_mtrig;
  logic                  r_cap;
  logic                  r_done;
  logic                  r_ovf;
  logic [TRIG_CNT_W-1:0] r_trig_cnt;

  // One phase counter serves all timed states; it restarts on every state change.
  always_comb begin
    w_cnt_last = '0;
    case (r_state)
      S_COMP_RST: w_cnt_last = CR_LAST;
      S_CAPTURE:  w_cnt_last = CAP_LAST;
      S_HOLDOFF:  w_cnt_last = HO_LAST;
      default:    w_cnt_last = '0;
    endcase
  end

  assign w_cnt_done = (r_cnt == w_cnt_last);

  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    if (stop_cmd) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start_cmd) w_next = S_COMP_RST;
        S_COMP_RST:     if (w_cnt_done) w_next = S_ARMED;
        S_ARMED:        if (triggered_in) w_next = S_CAPTURE;
        S_CAPTURE: begin
          if (fifo_full)       w_next = S_DONE;
          else if (w_cnt_done) w_next = continuous ? S_HOLDOFF : S_DONE;
        end
        S_HOLDOFF:      if (w_cnt_done) w_next = S_COMP_RST;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  // Events are derived from the chosen transition so stop_cmd masks them all.
  always_comb begin
    w_restart     = (r_state == S_IDLE || r_state == S_DONE) && (w_next == S_COMP_RST);
    w_trig_accept = (r_state == S_ARMED) && (w_next == S_CAPTURE);
    w_ovf_set     = (r_state == S_CAPTURE) && fifo_full && (w_next == S_DONE);
  end

`ifdef ACQ_AUTO_TRIG_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_SAT  = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_tmo;

  // Saturates after firing so a single pulse is issued per ARMED visit.
  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset)                                 r_tmo <= '0;
    else if (r_state != S_ARMED || w_next != S_ARMED) r_tmo <= '0;
    else if (r_tmo != TMO_SAT)                        r_tmo <= r_tmo + CNT_W'(1);
  end

  assign w_mtrig = (r_state == S_ARMED) && (w_next == S_ARMED) && (r_tmo == TMO_LAST);
`else
  assign w_mtrig = 1'b0;
`endif

  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset) begin
      r_armed    <= 1'b0;
      r_mreset   <= 1'b0;
      r_mtrig    <= 1'b0;
      r_cap      <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_trig_cnt <= '0;
    end else begin
      r_armed  <= (w_next == S_ARMED);
      r_mreset <= (w_next == S_COMP_RST);
      r_cap    <= (w_next == S_CAPTURE);
      r_done   <= (w_next == S_DONE);
      r_mtrig  <= w_mtrig;
      if (w_restart) begin
        r_ovf      <= 1'b0;
        r_trig_cnt <= '0;
      end else begin
        if (w_ovf_set)     r_ovf      <= 1'b1;
        if (w_trig_accept) r_trig_cnt <= r_trig_cnt + TRIG_CNT_W'(1);
      end
    end
  end

  assign armed_out          = r_armed;
  assign manual_reset_out   = r_mreset;
  assign manual_trigger_out = r_mtrig;
  assign capture_en         = r_cap;
  assign acq_done           = r_done;
  assign overflow           = r_ovf;
  assign trig_count         = r_trig_cnt;
  assign state_out          = r_state;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Bench for acquisition_sequencer: directed scenarios with literal pins plus
// randomized stimulus checked every cycle against a phase/countdown model.
`timescale 1ns/1ps
module tb_acquisition_sequencer;

  localparam int POST = 8;
  localparam int CR   = 4;
  localparam int HO   = 6;
  localparam int TMO  = 20;
  localparam int TW   = 3;
`ifdef ACQ_AUTO_TRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic module_reset = 1'b1;
  logic start_cmd = 1'b0;
  logic stop_cmd = 1'b0;
  logic continuous = 1'b0;
  logic trig_drv = 1'b0;
  logic fifo_full = 1'b0;
  logic triggered_in;
  logic armed_out, manual_reset_out, manual_trigger_out, capture_en, acq_done, overflow;
  logic [TW-1:0] trig_count;
  logic [2:0] state_out;

`ifdef ACQ_AUTO_TRIG_EN
  assign triggered_in = trig_drv | manual_trigger_out;
`else
  assign triggered_in = trig_drv;
`endif

  acquisition_sequencer #(
    .POST_TRIG_SAMPLES(POST), .CNT_W(16), .COMP_RESET_CYCLES(CR),
    .HOLDOFF_CYCLES(HO), .TIMEOUT_CYCLES(TMO), .TRIG_CNT_W(TW)
  ) dut (
    .clk(clk), .module_reset(module_reset), .start_cmd(start_cmd), .stop_cmd(stop_cmd),
    .continuous(continuous), .triggered_in(triggered_in), .fifo_full(fifo_full),
    .armed_out(armed_out), .manual_reset_out(manual_reset_out),
    .manual_trigger_out(manual_trigger_out), .capture_en(capture_en), .acq_done(acq_done),
    .overflow(overflow), .trig_count(trig_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Model: current phase (spec encoding), cycles left in timed phase, counters.
  int m_state = 0;
  int m_left = 0;
  int m_trig = 0;
  int m_age = 0;
  bit m_ovf = 1'b0;
  bit m_mtrig = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int phase_len(input int s);
    case (s)
      1:       return CR;
      3:       return POST;
      4:       return HO;
      default: return 0;
    endcase
  endfunction

  task automatic enter(input int s);
    m_state = s;
    m_left  = phase_len(s);
    m_age   = 0;
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_trig = 0; m_age = 0; m_ovf = 1'b0; m_mtrig = 1'b0;
  endtask

  task automatic model_step();
    m_mtrig = 1'b0;
    if (stop_cmd) begin
      m_state = 0;
      return;
    end
    case (m_state)
      0, 5: if (start_cmd) begin m_trig = 0; m_ovf = 1'b0; enter(1); end
      1: begin m_left--; if (m_left == 0) enter(2); end
      2: begin
        if (triggered_in) begin
          m_trig = (m_trig + 1) % (1 << TW);
          enter(3);
        end else begin
          m_age++;
          if (AUTO && m_age == TMO) m_mtrig = 1'b1;
        end
      end
      3: begin
        if (fifo_full) begin
          m_ovf = 1'b1;
          enter(5);
        end else begin
          m_left--;
          if (m_left == 0) enter(continuous ? 4 : 5);
        end
      end
      4: begin m_left--; if (m_left == 0) enter(1); end
      default: m_state = 0;
    endcase
  endtask

  task automatic compare();
    chk("state_out", int'(state_out), m_state);
    chk("armed_out", int'(armed_out), int'(m_state == 2));
    chk("manual_reset_out", int'(manual_reset_out), int'(m_state == 1));
    chk("capture_en", int'(capture_en), int'(m_state == 3));
    chk("acq_done", int'(acq_done), int'(m_state == 5));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("trig_count", int'(trig_count), m_trig);
    chk("manual_trigger_out", int'(manual_trigger_out), int'(m_mtrig));
  endtask

  // Advance one clock: model follows the edge, outputs are checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (module_reset) model_reset();
    else model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare();
    chk("reset_capture_en", int'(capture_en), 0);
    chk("reset_state", int'(state_out), 0);
    tick();
    module_reset = 1'b0;
    tick();

    // Single shot: start in cycle 0, trigger in cycle 10.
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    for (int k = 1; k <= CR; k++) begin
      chk("t1_mreset_on", int'(manual_reset_out), 1);
      chk("t1_armed_off", int'(armed_out), 0);
      tick();
    end
    chk("t1_armed_c5", int'(armed_out), 1);
    chk("t1_mreset_c5", int'(manual_reset_out), 0);
    repeat (5) tick();
    trig_drv = 1'b1; tick(); trig_drv = 1'b0;
    for (int k = 11; k <= 18; k++) begin
      chk("t1_capture_on", int'(capture_en), 1);
      tick();
    end
    chk("t1_capture_c19", int'(capture_en), 0);
    chk("t1_done_c19", int'(acq_done), 1);
    chk("t1_trig_count", int'(trig_count), 1);
    chk("t1_state_done", int'(state_out), 5);

    // Continuous, trigger held high so HOLDOFF/COMP_RST pulses must be ignored.
    continuous = 1'b1; trig_drv = 1'b1;
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    repeat (13) tick();
    chk("t2_holdoff_c14", int'(state_out), 4);
    chk("t2_holdoff_armed", int'(armed_out), 0);
    repeat (30) tick();
    chk("t2_capture_c44", int'(capture_en), 1);
    chk("t2_count_c44", int'(trig_count), 3);
    continuous = 1'b0;
    repeat (8) tick();
    trig_drv = 1'b0;
    chk("t2_state_done", int'(state_out), 5);
    chk("t2_trig_count", int'(trig_count), 3);

    // fifo_full in third capture cycle.
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    repeat (CR) tick();
    trig_drv = 1'b1; tick(); trig_drv = 1'b0;
    tick(); tick();
    fifo_full = 1'b1; tick(); fifo_full = 1'b0;
    chk("t3_capture_off", int'(capture_en), 0);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_state_done", int'(state_out), 5);

    // stop beats start while ARMED.
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    chk("t4_overflow_cleared", int'(overflow), 0);
    repeat (CR) tick();
    chk("t4_armed", int'(armed_out), 1);
    stop_cmd = 1'b1; start_cmd = 1'b1; tick(); stop_cmd = 1'b0; start_cmd = 1'b0;
    chk("t4_state_idle", int'(state_out), 0);
    chk("t4_armed_off", int'(armed_out), 0);

    // Async reset mid-capture, checked before any clock edge.
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    repeat (CR) tick();
    trig_drv = 1'b1; tick(); trig_drv = 1'b0;
    tick(); tick();
    chk("t5_capture_before", int'(capture_en), 1);
    module_reset = 1'b1;
    model_reset();
    #1;
    chk("t5_capture_async", int'(capture_en), 0);
    chk("t5_state_async", int'(state_out), 0);
    tick();
    module_reset = 1'b0;
    tick();

`ifdef ACQ_AUTO_TRIG_EN
    // No external trigger: timeout pulse loops back into triggered_in.
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    repeat (CR + TMO - 1) tick();
    chk("t6_no_pulse_yet", int'(manual_trigger_out), 0);
    tick();
    chk("t6_pulse", int'(manual_trigger_out), 1);
    tick();
    chk("t6_capture", int'(capture_en), 1);
    repeat (POST + 2) tick();
`endif

    // Randomized traffic including rare async resets.
    for (int i = 0; i < 3000; i++) begin
      start_cmd = ($urandom_range(0, 19) == 0);
      stop_cmd  = ($urandom_range(0, 59) == 0);
      trig_drv  = ($urandom_range(0, 7) == 0);
      fifo_full = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 31) == 0) continuous = ~continuous;
      if ($urandom_range(0, 499) == 0) begin
        module_reset = 1'b1;
        model_reset();
        #1;
        chk("rand_async_capture", int'(capture_en), 0);
      end else begin
        module_reset = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
